pinmux_switch_sequencer: RTL

//  Sequences source-select changes for the bidirectional (inout) pins of the pinmux.

---
 rtl/pinmux_switch_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pinmux_switch_sequencer.sv
// Glitch-free source-select sequencer for pinmux inout pins.
// One change at a time: OE off, switch select, settle, OE back on.
module pinmux_switch_sequencer #(
  parameter int unsigned PinNum      = 68,
  parameter int unsigned SelW        = 3,
  parameter int unsigned SelNum      = 5,
  parameter int unsigned GuardCycles = 4,
  localparam int unsigned PinW       = $clog2(PinNum)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [PinW-1:0]        req_pin_i,
  input  logic [SelW-1:0]        req_sel_i,
  input  logic                   lock_i,
  output logic [PinNum*SelW-1:0] sel_o,
  output logic [PinNum-1:0]      oe_mask_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned CntW = $clog2(GuardCycles + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(GuardCycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SETTLE
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PinW-1:0]   pin_q, pin_d;
  logic [SelW-1:0]   nsel_q, nsel_d;
  logic [SelW-1:0]   sel_q [PinNum];
  logic [SelW-1:0]   sel_d [PinNum];
  logic [PinNum-1:0] oe_q, oe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic            accept;
  logic            pin_ok;
  logic            sel_ok;
  logic [SelW-1:0] cur_sel;

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign pin_ok      = {1'b0, req_pin_i} < (PinW+1)'(PinNum);
  assign sel_ok      = {1'b0, req_sel_i} < (SelW+1)'(SelNum);
  assign cur_sel     = sel_q[req_pin_i];

  assign oe_mask_o = oe_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

  for (genvar p = 0; p < PinNum; p++) begin : g_sel
    assign sel_o[p*SelW +: SelW] = sel_q[p];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    nsel_d  = nsel_q;
    sel_d   = sel_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (lock_i || !pin_ok || !sel_ok) begin
            err_d = 1'b1;
          end else if (cur_sel == req_sel_i) begin
            done_d = 1'b1;
          end else begin
            pin_d          = req_pin_i;
            nsel_d         = req_sel_i;
            oe_d[req_pin_i] = 1'b0;
            cnt_d          = CntInit;
            state_d        = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sel_d[pin_q] = nsel_q;
          cnt_d        = CntInit;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          oe_d[pin_q] = 1'b1;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pin_q   <= '0;
      nsel_q  <= '0;
      oe_q    <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int p = 0; p < PinNum; p++) begin
        sel_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      nsel_q  <= nsel_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
    end
  end

endmodule
